// File: rtl/ntt_pkg.sv
// Shared types, sizes and schedule helpers for the NTT/INTT control sequencer.
package ntt_pkg;

    localparam int unsigned N                = 256;
    localparam int unsigned ADDR_W           = 8;
    localparam int unsigned TW_W             = 8;
    localparam int unsigned PAIR_W           = ADDR_W - 1;
    localparam int unsigned LAYER_W          = 3;
    localparam int unsigned KYBER_LAYERS     = 7;
    localparam int unsigned DILITHIUM_LAYERS = 8;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [TW_W-1:0]    tw_addr_t;
    typedef logic [PAIR_W-1:0]  pair_t;
    typedef logic [LAYER_W-1:0] layer_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic  valid;
        addr_t addr_a;
        addr_t addr_b;
    } wb_t;

    // log2 of the butterfly span for a layer
    function automatic logic [2:0] layer_lg(input layer_t layer, input logic red, input logic inv);
        if (inv) return layer + 3'(red);
        return 3'd7 - layer;
    endfunction

    // Coefficient a of pair p: the pair index with a zero bit inserted at position lg
    function automatic addr_t pair_addr_a(input pair_t p, input logic [2:0] lg);
        addr_t pe;
        addr_t lo_mask;
        pe      = addr_t'(p);
        lo_mask = (addr_t'(1) << lg) - addr_t'(1);
        return ((pe & ~lo_mask) << 1) | (pe & lo_mask);
    endfunction

    // True on the last pair of a group, where the twiddle index advances
    function automatic logic group_end(input pair_t p, input logic [2:0] lg);
        pair_t mask;
        mask = pair_t'((addr_t'(1) << lg) - addr_t'(1));
        return (p & mask) == mask;
    endfunction

endpackage

// File: rtl/ntt_wb_delay.sv
// Fixed-depth delay line turning issued pair reads into their write-backs.
module ntt_wb_delay
    import ntt_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  wb_t  wb_i,
    output wb_t  wb_o
);

    wb_t pipe_q [LAT];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(LAT); i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= wb_i;
            for (int i = 1; i < int'(LAT); i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign wb_o = pipe_q[LAT-1];

endmodule

// File: rtl/ntt_sequencer.sv
// Layer-by-layer pair/twiddle sequencer for the in-place Kyber/Dilithium NTT butterfly.
module ntt_sequencer
    import ntt_pkg::*;
#(
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             sel_red_i,
    input  logic             inverse_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_a_o,
    output logic [ADDR_W-1:0] rd_addr_b_o,
    output logic [TW_W-1:0]   tw_addr_o,
    output logic             sel_red_o,
    output logic             sel_butterfly_o,
    output logic             wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_a_o,
    output logic [ADDR_W-1:0] wr_addr_b_o
);

    localparam int unsigned DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    state_t               state_q, state_d;
    pair_t                pair_q, pair_d;
    layer_t               layer_q, layer_d;
    tw_addr_t             k_q, k_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 red_q, red_d, inv_q, inv_d;
    logic                 busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
    addr_t                rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    tw_addr_t             tw_q, tw_d;
    logic [2:0]           lg_cur, lg_nxt;
    layer_t               last_layer;
    wb_t                  wb_in, wb_out;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            pair_q  <= '0;
            layer_q <= '0;
            k_q     <= '0;
            drain_q <= '0;
            red_q   <= 1'b0;
            inv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
        end else begin
            state_q <= state_d;
            pair_q  <= pair_d;
            layer_q <= layer_d;
            k_q     <= k_d;
            drain_q <= drain_d;
            red_q   <= red_d;
            inv_q   <= inv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            tw_q    <= tw_d;
        end
    end

    // Next state, schedule counters, and registered outputs derived from the next state
    always_comb begin
        state_d    = state_q;
        pair_d     = pair_q;
        layer_d    = layer_q;
        k_d        = k_q;
        drain_d    = drain_q;
        red_d      = red_q;
        inv_d      = inv_q;
        lg_cur     = layer_lg(layer_q, red_q, inv_q);
        last_layer = red_q ? layer_t'(KYBER_LAYERS - 1) : layer_t'(DILITHIUM_LAYERS - 1);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = ISSUE;
                    red_d   = sel_red_i;
                    inv_d   = inverse_i;
                    pair_d  = '0;
                    layer_d = '0;
                    drain_d = '0;
                    k_d     = inverse_i ? (sel_red_i ? tw_addr_t'(127) : tw_addr_t'(255))
                                        : tw_addr_t'(1);
                end
            end
            ISSUE: begin
                pair_d = pair_q + pair_t'(1);
                if (group_end(pair_q, lg_cur) && !((pair_q == '1) && (layer_q == last_layer)))
                    k_d = inv_q ? (k_q - tw_addr_t'(1)) : (k_q + tw_addr_t'(1));
                if (pair_q == '1) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_W'(PIPE_LAT - 1)) begin
                    if (layer_q == last_layer) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        layer_d = layer_q + layer_t'(1);
                    end
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        lg_nxt  = layer_lg(layer_d, red_d, inv_d);
        rd_en_d = (state_d == ISSUE);
        rd_a_d  = rd_en_d ? pair_addr_a(pair_d, lg_nxt) : '0;
        rd_b_d  = rd_en_d ? (rd_a_d | (addr_t'(1) << lg_nxt)) : '0;
        tw_d    = rd_en_d ? k_d : '0;
        busy_d  = (state_d == ISSUE) || (state_d == DRAIN);
        done_d  = (state_d == DONE);
    end

    assign wb_in.valid  = rd_en_q;
    assign wb_in.addr_a = rd_a_q;
    assign wb_in.addr_b = rd_b_q;

    ntt_wb_delay #(.LAT(PIPE_LAT)) u_wb_delay (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .wb_i    (wb_in),
        .wb_o    (wb_out)
    );

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign rd_en_o         = rd_en_q;
    assign rd_addr_a_o     = rd_a_q;
    assign rd_addr_b_o     = rd_b_q;
    assign tw_addr_o       = tw_q;
    assign sel_red_o       = red_q;
    assign sel_butterfly_o = inv_q;
    assign wr_en_o         = wb_out.valid;
    assign wr_addr_a_o     = wb_out.addr_a;
    assign wr_addr_b_o     = wb_out.addr_b;

endmodule

// File: tb/tb_ntt_sequencer.sv
// Directed bench for ntt_sequencer: schedule, write echo, latency, start/reset corner cases.
module tb_ntt_sequencer;
    import ntt_pkg::*;

    localparam int unsigned PIPE_LAT = 2;
    localparam int          T        = 128 + PIPE_LAT;

    logic              clk = 1'b0;
    logic              rst_n_i, start_i, sel_red_i, inverse_i;
    logic              busy_o, done_o, rd_en_o, sel_red_o, sel_butterfly_o, wr_en_o;
    logic [ADDR_W-1:0] rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;
    logic [TW_W-1:0]   tw_addr_o;

    always #5 clk = ~clk;

    ntt_sequencer #(.PIPE_LAT(PIPE_LAT)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n_i),
        .start_i         (start_i),
        .sel_red_i       (sel_red_i),
        .inverse_i       (inverse_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .rd_en_o         (rd_en_o),
        .rd_addr_a_o     (rd_addr_a_o),
        .rd_addr_b_o     (rd_addr_b_o),
        .tw_addr_o       (tw_addr_o),
        .sel_red_o       (sel_red_o),
        .sel_butterfly_o (sel_butterfly_o),
        .wr_en_o         (wr_en_o),
        .wr_addr_a_o     (wr_addr_a_o),
        .wr_addr_b_o     (wr_addr_b_o)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_layers = 0;
    int wr_count = 0;
    int ea [1024];
    int eb [1024];
    int ek [1024];

    typedef struct packed {
        bit red;
        bit inv;
        int c;
        int a;
        int b;
        int k;
    } spot_t;

    // Hand-computed schedule points
    spot_t spots [9] = '{
        '{1'b1, 1'b0,    0,   0, 128,   1},
        '{1'b1, 1'b0,  127, 127, 255,   1},
        '{1'b1, 1'b0,  130,   0,  64,   2},
        '{1'b1, 1'b0,  194, 128, 192,   3},
        '{1'b1, 1'b0,  907, 253, 255, 127},
        '{1'b0, 1'b0, 1037, 254, 255, 255},
        '{1'b1, 1'b1,    0,   0,   2, 127},
        '{1'b1, 1'b1,    2,   4,   6, 126},
        '{1'b1, 1'b1,  780,   0, 128,   1}
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        else
            n_pass++;
    endtask

    // Reference schedule built straight from the layer/group/pair loops
    task automatic build_model(input bit red, input bit inv);
        int k;
        int len;
        int idx;
        n_layers = red ? 7 : 8;
        k        = inv ? (red ? 127 : 255) : 1;
        idx      = 0;
        for (int l = 0; l < n_layers; l++) begin
            len = inv ? ((red ? 2 : 1) << l) : (128 >> l);
            for (int s = 0; s < 256; s += 2 * len) begin
                for (int j = s; j < s + len; j++) begin
                    ea[idx] = j;
                    eb[idx] = j + len;
                    ek[idx] = k;
                    idx++;
                end
                k = inv ? k - 1 : k + 1;
            end
        end
    endtask

    function automatic bit exp_rd(input int c);
        return (c >= 0) && (c < n_layers * T) && ((c % T) < 128);
    endfunction

    function automatic int exp_idx(input int c);
        return (c / T) * 128 + (c % T);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 32'({busy_o, done_o, rd_en_o, wr_en_o, sel_red_o, sel_butterfly_o}), 32'd0);
        check({tag, "_rd"}, 32'({rd_addr_a_o, rd_addr_b_o, tw_addr_o}), 32'd0);
        check({tag, "_wr"}, 32'({wr_addr_a_o, wr_addr_b_o}), 32'd0);
    endtask

    // One full operation; cycle 0 is the first issue cycle after the start pulse
    task automatic run(input bit red, input bit inv, input int busy_start_at,
                       input int reset_at, input bit start_in_done);
        int  d;
        int  i;
        bit  in_reset;
        build_model(red, inv);
        d        = n_layers * T;
        wr_count = 0;
        in_reset = 1'b0;
        sel_red_i = red;
        inverse_i = inv;
        start_i   = 1'b1;
        for (int c = 0; c <= d + 1; c++) begin
            @(negedge clk);
            cyc       = c;
            start_i   = 1'b0;
            sel_red_i = red;
            inverse_i = inv;
            if (in_reset) begin
                rst_n_i = 1'b1;
                check_all_zero("post_reset");
                if (c >= reset_at + 200) break;
                continue;
            end
            check("rd_en", 32'(rd_en_o), 32'(exp_rd(c)));
            if (exp_rd(c)) begin
                i = exp_idx(c);
                check("rd_pair", 32'({rd_addr_a_o, rd_addr_b_o, tw_addr_o}),
                      32'((ea[i] << 16) | (eb[i] << 8) | ek[i]));
            end
            check("wr_en", 32'(wr_en_o), 32'(exp_rd(c - int'(PIPE_LAT))));
            if (exp_rd(c - int'(PIPE_LAT))) begin
                i = exp_idx(c - int'(PIPE_LAT));
                check("wr_pair", 32'({wr_addr_a_o, wr_addr_b_o}), 32'((ea[i] << 8) | eb[i]));
            end
            if (wr_en_o) wr_count++;
            check("busy", 32'(busy_o), 32'(c < d));
            check("done", 32'(done_o), 32'(c == d));
            check("mode", 32'({sel_red_o, sel_butterfly_o}), 32'({red, inv}));
            foreach (spots[s]) begin
                if (spots[s].red == red && spots[s].inv == inv && spots[s].c == c)
                    check("spot", 32'({rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o}),
                          32'((1 << 24) | (spots[s].a << 16) | (spots[s].b << 8) | spots[s].k));
            end
            if (c == busy_start_at || (c == d && start_in_done)) begin
                start_i   = 1'b1;
                sel_red_i = ~red;
                inverse_i = ~inv;
            end
            if (c == reset_at) begin
                rst_n_i  = 1'b0;
                in_reset = 1'b1;
            end
        end
        start_i = 1'b0;
        if (reset_at < 0) check("wr_count", 32'(wr_count), 32'(128 * n_layers));
    endtask

    initial begin
        rst_n_i   = 1'b0;
        start_i   = 1'b0;
        sel_red_i = 1'b0;
        inverse_i = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n_i = 1'b1;
        @(negedge clk);

        run(1'b1, 1'b0, -1,  -1, 1'b1);   // Kyber forward, start during DONE ignored
        run(1'b0, 1'b0, -1,  -1, 1'b0);   // Dilithium forward, started right after DONE
        run(1'b1, 1'b1, -1,  -1, 1'b0);   // Kyber inverse
        run(1'b0, 1'b1, 50,  -1, 1'b0);   // Dilithium inverse, start while busy
        run(1'b1, 1'b0, -1, 300, 1'b0);   // Kyber forward, reset mid-run
        run(1'b1, 1'b0, 50,  -1, 1'b0);   // fresh Kyber forward after reset

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
